// File: rtl/branch_predictor_gshare.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor_gshare
// Brief    : Direction (static/bimodal/gshare PHT) and target (direct-mapped
//            BTB) predictor with combinational lookup and perf counters.
// Revision : 1.0 - initial release
// ============================================================================
module branch_predictor_gshare #(
  parameter int BHR_WIDTH = 3,
  parameter int PHT_IDX_W = 6,
  parameter int BTB_IDX_W = 4,
  parameter int PRED_MODE = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          fetch_pc,
  output logic                 pred_taken,
  output logic [31:0]          pred_target,
  output logic                 pred_hit,
  output logic [BHR_WIDTH-1:0] pred_bhr,
  input  logic                 upd_valid,
  input  logic [31:0]          upd_pc,
  input  logic                 upd_is_branch,
  input  logic                 upd_is_jump,
  input  logic                 upd_taken,
  input  logic [31:0]          upd_target,
  input  logic [BHR_WIDTH-1:0] upd_bhr,
  input  logic                 upd_pred_taken,
  output logic [31:0]          perf_branches,
  output logic [31:0]          perf_mispredicts
);

  localparam int         PHT_N       = 1 << PHT_IDX_W;
  localparam int         BTB_N       = 1 << BTB_IDX_W;
  localparam int         TAG_W       = 30 - BTB_IDX_W;
  localparam logic [1:0] PHT_INIT    = 2'b01;
  localparam logic [1:0] PHT_MAX     = 2'b11;
  localparam logic [1:0] PHT_MIN     = 2'b00;
  localparam logic [31:0] PERF_MAX   = 32'hFFFF_FFFF;

  logic [1:0]           pht        [PHT_N];
  logic                 btb_valid  [BTB_N];
  logic                 btb_jump   [BTB_N];
  logic [TAG_W-1:0]     btb_tag    [BTB_N];
  logic [31:0]          btb_target [BTB_N];
  logic [BHR_WIDTH-1:0] bhr;
  logic [BHR_WIDTH-1:0] bhr_next;
  logic [31:0]          branches;
  logic [31:0]          mispredicts;

  logic [BTB_IDX_W-1:0] f_btb_idx;
  logic [TAG_W-1:0]     f_tag;
  logic [PHT_IDX_W-1:0] f_pht_idx;
  logic [BTB_IDX_W-1:0] u_btb_idx;
  logic [TAG_W-1:0]     u_tag;
  logic [PHT_IDX_W-1:0] u_pht_idx;
  logic [PHT_IDX_W-1:0] f_hist;
  logic [PHT_IDX_W-1:0] u_hist;
  logic                 f_hit;
  logic                 upd_br;
  logic                 upd_cf;
  logic                 unused_bits;

  assign unused_bits = ^{fetch_pc[1:0], upd_pc[1:0]};

  // History only folds into the index in gshare mode.
  assign f_hist = (PRED_MODE == 2) ? PHT_IDX_W'(bhr)     : '0;
  assign u_hist = (PRED_MODE == 2) ? PHT_IDX_W'(upd_bhr) : '0;

  assign f_btb_idx = fetch_pc[BTB_IDX_W+1:2];
  assign f_tag     = fetch_pc[31:BTB_IDX_W+2];
  assign f_pht_idx = fetch_pc[PHT_IDX_W+1:2] ^ f_hist;
  assign u_btb_idx = upd_pc[BTB_IDX_W+1:2];
  assign u_tag     = upd_pc[31:BTB_IDX_W+2];
  assign u_pht_idx = upd_pc[PHT_IDX_W+1:2] ^ u_hist;

  assign f_hit       = btb_valid[f_btb_idx] && (btb_tag[f_btb_idx] == f_tag);
  assign pred_hit    = f_hit;
  assign pred_target = f_hit ? btb_target[f_btb_idx] : 32'd0;
  assign pred_taken  = (PRED_MODE != 0) && f_hit &&
                       (btb_jump[f_btb_idx] || pht[f_pht_idx][1]);
  assign pred_bhr         = bhr;
  assign perf_branches    = branches;
  assign perf_mispredicts = mispredicts;

  // A simultaneous branch+jump is illegal and handled as a plain jump.
  assign upd_br = upd_valid && upd_is_branch && !upd_is_jump;
  assign upd_cf = upd_br || (upd_valid && upd_is_jump);

  generate
    if (BHR_WIDTH == 1) begin : g_bhr_single
      assign bhr_next = upd_taken;
    end else begin : g_bhr_shift
      assign bhr_next = {bhr[BHR_WIDTH-2:0], upd_taken};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < PHT_N; i++) begin
        pht[i] <= PHT_INIT;
      end
      for (int i = 0; i < BTB_N; i++) begin
        btb_valid[i] <= 1'b0;
      end
      bhr         <= '0;
      branches    <= 32'd0;
      mispredicts <= 32'd0;
    end else begin
      if (upd_br && (PRED_MODE != 0)) begin
        if (upd_taken && (pht[u_pht_idx] != PHT_MAX)) begin
          pht[u_pht_idx] <= pht[u_pht_idx] + 2'd1;
        end else if (!upd_taken && (pht[u_pht_idx] != PHT_MIN)) begin
          pht[u_pht_idx] <= pht[u_pht_idx] - 2'd1;
        end
      end
      if (upd_br) begin
        bhr <= bhr_next;
      end
      if (upd_cf && upd_taken) begin
        btb_valid[u_btb_idx]  <= 1'b1;
        btb_jump[u_btb_idx]   <= upd_is_jump;
        btb_tag[u_btb_idx]    <= u_tag;
        btb_target[u_btb_idx] <= upd_target;
      end
      if (upd_cf && (branches != PERF_MAX)) begin
        branches <= branches + 32'd1;
      end
      if (upd_br && (upd_pred_taken != upd_taken) && (mispredicts != PERF_MAX)) begin
        mispredicts <= mispredicts + 32'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor_gshare.sv
`default_nettype none
// Bench for branch_predictor_gshare: a bimodal and a gshare instance share
// stimulus and are compared against an array-based model of the predictor.
module tb_branch_predictor_gshare;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] fetch_pc, upd_pc, upd_target;
  logic        upd_valid, upd_is_branch, upd_is_jump, upd_taken, upd_pred_taken;
  logic [2:0]  upd_bhr;

  logic        b_taken, b_hit, g_taken, g_hit;
  logic [31:0] b_target, g_target, b_br, b_mp, g_br, g_mp;
  logic [2:0]  b_bhr, g_bhr;

  branch_predictor_gshare #(.BHR_WIDTH(3), .PHT_IDX_W(6), .BTB_IDX_W(4), .PRED_MODE(1)) u_bim (
    .clk(clk), .rst(rst), .fetch_pc(fetch_pc),
    .pred_taken(b_taken), .pred_target(b_target), .pred_hit(b_hit), .pred_bhr(b_bhr),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_branch(upd_is_branch),
    .upd_is_jump(upd_is_jump), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_bhr(upd_bhr), .upd_pred_taken(upd_pred_taken),
    .perf_branches(b_br), .perf_mispredicts(b_mp)
  );

  branch_predictor_gshare #(.BHR_WIDTH(3), .PHT_IDX_W(6), .BTB_IDX_W(4), .PRED_MODE(2)) u_gsh (
    .clk(clk), .rst(rst), .fetch_pc(fetch_pc),
    .pred_taken(g_taken), .pred_target(g_target), .pred_hit(g_hit), .pred_bhr(g_bhr),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_branch(upd_is_branch),
    .upd_is_jump(upd_is_jump), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_bhr(upd_bhr), .upd_pred_taken(upd_pred_taken),
    .perf_branches(g_br), .perf_mispredicts(g_mp)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: index 0 = bimodal, 1 = gshare.
  int          m_pht [2][64];
  bit          m_val [2][16];
  bit          m_jmp [2][16];
  logic [31:0] m_pc  [2][16];
  logic [31:0] m_tgt [2][16];
  int          m_bhr [2];
  longint      m_br  [2];
  longint      m_mp  [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 64; i++) m_pht[k][i] = 1;
      for (int i = 0; i < 16; i++) m_val[k][i] = 1'b0;
      m_bhr[k] = 0;
      m_br[k]  = 0;
      m_mp[k]  = 0;
    end
  endtask

  task automatic model_update();
    bit isbr, cf;
    int pi, bi;
    if (!rst) begin
      model_reset();
      return;
    end
    if (!upd_valid) return;
    isbr = upd_is_branch && !upd_is_jump;
    cf   = isbr || upd_is_jump;
    for (int k = 0; k < 2; k++) begin
      if (isbr) begin
        pi = int'((upd_pc / 4) % 64) ^ ((k == 1) ? int'(upd_bhr) : 0);
        if (upd_taken) m_pht[k][pi] = (m_pht[k][pi] >= 3) ? 3 : m_pht[k][pi] + 1;
        else           m_pht[k][pi] = (m_pht[k][pi] <= 0) ? 0 : m_pht[k][pi] - 1;
        m_bhr[k] = (m_bhr[k] * 2 + (upd_taken ? 1 : 0)) % 8;
      end
      if (cf && upd_taken) begin
        bi = int'((upd_pc / 4) % 16);
        m_val[k][bi] = 1'b1;
        m_jmp[k][bi] = upd_is_jump;
        m_pc[k][bi]  = upd_pc;
        m_tgt[k][bi] = upd_target;
      end
      if (cf && m_br[k] < 64'hFFFF_FFFF) m_br[k]++;
      if (isbr && (upd_pred_taken != upd_taken) && m_mp[k] < 64'hFFFF_FFFF) m_mp[k]++;
    end
  endtask

  function automatic logic [127:0] mexp(int k);
    int bi, pi;
    bit hit, tk;
    logic [31:0] tgt;
    bi  = int'((fetch_pc / 4) % 16);
    pi  = int'((fetch_pc / 4) % 64) ^ ((k == 1) ? m_bhr[k] : 0);
    hit = m_val[k][bi] && ((m_pc[k][bi] / 64) == (fetch_pc / 64));
    tgt = hit ? m_tgt[k][bi] : 32'd0;
    tk  = hit && (m_jmp[k][bi] || m_pht[k][pi] >= 2);
    return {27'b0, tk, hit, tgt, 3'(m_bhr[k]), m_br[k][31:0], m_mp[k][31:0]};
  endfunction

  function automatic logic [127:0] dut_act(int k);
    if (k == 0) return {27'b0, b_taken, b_hit, b_target, b_bhr, b_br, b_mp};
    return {27'b0, g_taken, g_hit, g_target, g_bhr, g_br, g_mp};
  endfunction

  task automatic look();
    @(negedge clk);
    chk("bimodal_vs_model", dut_act(0), mexp(0));
    chk("gshare_vs_model", dut_act(1), mexp(1));
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
    model_update();
  endtask

  task automatic set_upd(bit v, bit br, bit jmp, bit tk, bit pt, logic [31:0] pc,
                         logic [31:0] tgt, logic [2:0] hb);
    upd_valid = v; upd_is_branch = br; upd_is_jump = jmp; upd_taken = tk;
    upd_pred_taken = pt; upd_pc = pc; upd_target = tgt; upd_bhr = hb;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    set_upd(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'h0);
    look();
    edge_step();
    rst = 1'b1;
  endtask

  typedef struct {
    bit          v, br, jmp, tk, pt;
    logic [31:0] pc, tgt, fpc;
    bit          e_hit, e_tk;
    logic [31:0] e_tgt, e_br, e_mp;
  } vec_t;

  function automatic vec_t mk(bit v, bit br, bit jmp, bit tk, bit pt, logic [31:0] pc,
                              logic [31:0] tgt, logic [31:0] fpc, bit eh, bit et,
                              logic [31:0] etg, logic [31:0] ebr, logic [31:0] emp);
    vec_t r;
    r.v = v; r.br = br; r.jmp = jmp; r.tk = tk; r.pt = pt; r.pc = pc; r.tgt = tgt;
    r.fpc = fpc; r.e_hit = eh; r.e_tk = et; r.e_tgt = etg; r.e_br = ebr; r.e_mp = emp;
    return r;
  endfunction

  vec_t        tbl [12];
  logic [31:0] pool [9];

  initial begin
    // Bimodal training on pc 0x100 (PHT/BTB index 0), then aliasing and corner updates.
    tbl[0]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 32'h80,  32'h100, 1'b1, 1'b1, 32'h80,  32'd1,  32'd1);
    tbl[1]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 32'h80,  32'h100, 1'b1, 1'b1, 32'h80,  32'd2,  32'd1);
    tbl[2]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 32'h80,  32'h100, 1'b1, 1'b1, 32'h80,  32'd3,  32'd2);
    tbl[3]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 32'h80,  32'h100, 1'b1, 1'b0, 32'h80,  32'd4,  32'd3);
    tbl[4]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h80,  32'h100, 1'b1, 1'b0, 32'h80,  32'd5,  32'd3);
    tbl[5]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h80,  32'h100, 1'b1, 1'b0, 32'h80,  32'd6,  32'd3);
    tbl[6]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 32'h80,  32'h100, 1'b1, 1'b0, 32'h80,  32'd7,  32'd4);
    tbl[7]  = mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h140, 32'h200, 32'h100, 1'b0, 1'b0, 32'h0,   32'd8,  32'd4);
    tbl[8]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   32'h140, 1'b1, 1'b1, 32'h200, 32'd8,  32'd4);
    tbl[9]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h300, 32'h44,  32'h300, 1'b0, 1'b0, 32'h0,   32'd8,  32'd4);
    tbl[10] = mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h184, 32'h400, 32'h184, 1'b1, 1'b1, 32'h400, 32'd9,  32'd4);
    tbl[11] = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h188, 32'h500, 32'h188, 1'b0, 1'b0, 32'h0,   32'd10, 32'd5);

    pool = '{32'h0, 32'h40, 32'h100, 32'h104, 32'h140, 32'h200, 32'h7FC, 32'h1000, 32'h1040};

    model_reset();
    fetch_pc = 32'h60;
    do_reset();

    @(negedge clk);
    chk("reset_bimodal", dut_act(0), 128'd0);
    chk("reset_gshare", dut_act(1), 128'd0);
    edge_step();

    foreach (tbl[i]) begin
      set_upd(tbl[i].v, tbl[i].br, tbl[i].jmp, tbl[i].tk, tbl[i].pt, tbl[i].pc, tbl[i].tgt, 3'h0);
      fetch_pc = tbl[i].fpc;
      look();
      edge_step();
      set_upd(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'h0);
      look();
      chk($sformatf("table_row%0d", i),
          {b_hit, b_taken, b_target, b_br, b_mp},
          {tbl[i].e_hit, tbl[i].e_tk, tbl[i].e_tgt, tbl[i].e_br, tbl[i].e_mp});
      edge_step();
    end

    // Same-cycle lookup and update: pre-update state visible, new state next cycle.
    do_reset();
    fetch_pc = 32'h100;
    set_upd(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 32'h80, 3'h0);
    look();
    chk("same_cycle_pre_hit", {31'b0, b_hit}, 32'd0);
    edge_step();
    set_upd(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'h0);
    look();
    chk("same_cycle_post_hit", {31'b0, b_hit}, 32'd1);
    edge_step();

    // Reset wins over a coincident update.
    rst = 1'b0;
    fetch_pc = 32'h140;
    set_upd(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h140, 32'h200, 3'h0);
    look();
    edge_step();
    rst = 1'b1;
    set_upd(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'h0);
    look();
    chk("reset_beats_update", {g_hit, g_bhr, g_br, b_hit, b_br}, 128'd0);
    edge_step();

    // Gshare: train index 0^5 via snapshot 101, then steer the live BHR to 101.
    do_reset();
    fetch_pc = 32'h800;
    for (int n = 0; n < 2; n++) begin
      set_upd(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h40, 3'b101);
      look();
      edge_step();
    end
    set_upd(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h20, 32'h60, 3'b000); look(); edge_step();
    set_upd(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h24, 32'h60, 3'b000); look(); edge_step();
    set_upd(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h28, 32'h60, 3'b000); look(); edge_step();
    set_upd(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'h0);
    fetch_pc = 32'h0;
    look();
    chk("gshare_bhr", {29'b0, g_bhr}, 32'd5);
    chk("gshare_taken_hit_target", {g_taken, g_hit, g_target}, {1'b1, 1'b1, 32'h40});
    edge_step();

    // Randomized traffic over a small PC pool to provoke hits and aliases.
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 49) != 0);
      set_upd($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom_range(0, 4) == 0),
              1'($urandom), 1'($urandom), pool[$urandom_range(0, 8)],
              $urandom, 3'($urandom));
      fetch_pc = pool[$urandom_range(0, 8)];
      look();
      edge_step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/branch_predictor_gshare.md
Name: branch_predictor_gshare

Overview:
- Parametrised direction + target predictor for the pipelined RV32I core.
- Successor to the fixed 3-bit-BHR predictor state carried in the stage registers: configurable history width, PHT size, BTB depth and mode (static / bimodal / gshare), plus perf counters.
- Lookup is combinational on the fetch PC in IF. Update arrives from the branch-resolution stage with the history snapshot taken at prediction time.

Parameters:
- BHR_WIDTH, 3, global history bits (1..PHT_IDX_W).
- PHT_IDX_W, 6, log2 of PHT entries (2-bit counters).
- BTB_IDX_W, 4, log2 of BTB entries (direct-mapped).
- PRED_MODE, 2, 0 = static not-taken, 1 = bimodal, 2 = gshare.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-low reset (rst=0 resets on the clock edge).
- fetch_pc  in  32  IF-stage PC for lookup.
- pred_taken  out  1  predicted taken.
- pred_target  out  32  BTB target; 0 when no hit.
- pred_hit  out  1  BTB tag hit.
- pred_bhr  out  BHR_WIDTH  current global history; IF carries it down the pipe.
- upd_valid  in  1  resolution update strobe.
- upd_pc  in  32  PC of the resolved control-flow instruction.
- upd_is_branch  in  1  conditional branch.
- upd_is_jump  in  1  jal/jalr (unconditional).
- upd_taken  in  1  actual outcome.
- upd_target  in  32  actual target.
- upd_bhr  in  BHR_WIDTH  history snapshot returned from pred_bhr.
- upd_pred_taken  in  1  direction that was predicted.
- perf_branches  out  32  count of resolved updates.
- perf_mispredicts  out  32  count of direction mispredicts.

Behaviour:
- State:
  - PHT of 2^PHT_IDX_W 2-bit counters.
  - BTB of 2^BTB_IDX_W entries, each {valid, jump, tag[31:BTB_IDX_W+2], target[31:0]}.
  - BHR register.
  - Two perf counters.
- Reset (rst=0 at posedge):
  - All PHT counters = 2'b01 (weakly not-taken).
  - All BTB valid = 0; BHR = 0; perf counters = 0.
  - Reset wins over a coincident upd_valid.
  - Outputs are combinational from state, so after reset: pred_taken=0, pred_hit=0, pred_target=0, pred_bhr=0, perf_*=0.
- Indexing:
  - btb_idx = pc[BTB_IDX_W+1:2]; tag = pc[31:BTB_IDX_W+2].
  - PHT index, bimodal: pc[PHT_IDX_W+1:2].
  - PHT index, gshare: pc[PHT_IDX_W+1:2] XOR zero-extended history. Lookup uses the current BHR; update uses upd_bhr.
- Lookup (0-cycle, combinational):
  - pred_hit = valid && tag match.
  - pred_target = hit ? target : 0.
  - pred_taken:
    - PRED_MODE 0: always 0.
    - Otherwise: hit && (jump || counter[1]).
- Update (when upd_valid=1 and rst=1, on posedge):
  - If upd_is_branch and PRED_MODE != 0:
    - PHT counter increments if taken, decrements if not.
    - Saturates at 2'b11 and 2'b00.
  - If upd_is_branch: BHR <= {BHR[BHR_WIDTH-2:0], upd_taken}. For BHR_WIDTH=1, BHR <= upd_taken.
  - If upd_taken (branch or jump):
    - BTB[idx] <= {1, upd_is_jump, tag, upd_target}.
    - Overwrites any aliasing entry.
  - A not-taken branch leaves the BTB unchanged.
  - perf_branches += 1 when upd_is_branch or upd_is_jump.
  - perf_mispredicts += 1 when upd_is_branch and upd_pred_taken != upd_taken.
  - Both perf counters saturate at 32'hFFFF_FFFF.
  - upd_valid with neither is_branch nor is_jump is a no-op.
- Simultaneous lookup and update of the same entry:
  - No bypass; lookup returns the pre-update state.
  - The new state is visible from the next cycle.
- upd_is_branch and upd_is_jump both 1: illegal. The block treats the update as a jump (no PHT/BHR change).

Test Plan:
1. rst=0 for one cycle, then rst=1; fetch_pc=0x60 -> pred_taken=0, pred_hit=0, pred_target=0, pred_bhr=3'b000, perf_*=0.
2. PRED_MODE=1; one update pc=0x100, branch, taken, target 0x80 -> next cycle fetch_pc=0x100 gives pred_hit=1, pred_taken=1 (counter 01->10), pred_target=0x80, perf_branches=1.
3. Continuing from 2: taken once (counter 11), then not-taken x4 -> counter 00, not-taken pred; then one taken -> counter 01, pred_taken=0 while pred_hit=1; perf_mispredicts increments for each update where upd_pred_taken != upd_taken.
4. BTB alias: taken update pc=0x100 target 0x80, then taken jump pc=0x140 target 0x200 (both idx 0) -> lookup 0x100 gives pred_hit=0, pred_taken=0; lookup 0x140 gives pred_taken=1 (jump), target 0x200.
5. Same-cycle: fetch_pc=0x100 while upd_valid trains pc=0x100 taken from reset -> that cycle pred_hit=0; next cycle pred_hit=1. Separately, rst=0 coincident with upd_valid -> all state reset, no update applied.
6. PRED_MODE=2, BHR_WIDTH=3: taken updates at pc=0x0 with upd_bhr=3'b101 twice (PHT idx 5 -> 11); drive BHR to 101 via branch outcomes T,N,T at other pcs -> lookup pc=0x0 gives pred_bhr=3'b101, pred_taken=1.
